muller_c_proj_formal_wrap: RTL and testbench
============================================

// Module: muller_c_proj_formal_wrap
// PURPOSE
// - Clocked model of a Muller C-element array used as the formal/cover harness of muller_c_proj.
// - io_in[5:0] is split into three 2-input C-elements.
// - A fourth C-element combines the three outputs into one "all agree" flag.
// - Per-element saturating transition counters support coverage and debug.
// - Sits between the user-project pad bus and the formal/cover flow; it has no downstream datapath.
// PARAMETERS
// - RESET_VAL  1'b0  value loaded into every C-element state bit on reset.
// - CNT_W      8     width of each per-element transition counter.
// PORTS
// - clk        in   1        single clock; all state updates on posedge.
// - rst_n      in   1        asynchronous, active-low reset.
// - io_in      in   6        {b2,a2,b1,a1,b0,a0}; element i uses a=io_in[2i], b=io_in[2i+1].
// - c_out      out  3        registered C-element states; c_out[i] belongs to element i.
// - c_all      out  1        registered C-element over c_out[2:0].
// - tog_cnt    out  3*CNT_W  per-element transition counters; element i in [i*CNT_W +: CNT_W].
// - fault      out  1        sticky flag; set when a state bit changes while its inputs disagree.
// BEHAVIOUR
// - Reset (rst_n=0, async, any time):
//   - c_out and c_all are forced to {RESET_VAL}.
//   - tog_cnt and fault are cleared to 0.
//   - Outputs stay forced until the first posedge with rst_n=1.
// - C-element rule, per element, per posedge: c_next = (a&b) | (c&(a|b)).
//   - a=b=1: output goes to 1.
//   - a=b=0: output goes to 0.
//   - a!=b: output holds its current value.
// - Latency:
//   - io_in to c_out: 1 cycle. io_in is sampled directly, with no input register.
//   - io_in to c_all: 2 cycles. c_all uses the same rule on c_out[2:0], so it is 1 if all three are 1,
//     0 if all three are 0, and holds otherwise.
// - tog_cnt[i] increments by 1 on each cycle where c_out[i] changes value.
//   - Saturates at 2^CNT_W-1; it never wraps.
// - fault is a consistency monitor and must stay 0 in a correct implementation.
//   - Sets if any c_out bit changes on an edge where its sampled a!=b.
//   - Once set, cleared only by reset.
// - Reset released with a!=b: outputs hold RESET_VAL indefinitely. This is legal; no spurious transition.
// - io_in is treated as already synchronous. No handshake, no backpressure, no X-propagation filtering.
// CONFIGURATION
// - Macro FORMAL_PROPS_EN.
// - When defined, the module includes immediate/concurrent properties, gated by rst_n:
//   - assert: c_out[i] changes only when a==b.
//   - assert: fault never set.
//   - assert: tog_cnt[i] is monotonic.
//   - cover: each c_out bit rising.
//   - cover: each c_out bit falling.
//   - cover: c_all reaching 1.
// - When undefined, no property code is compiled.
// - Ports and functional behaviour are identical in both builds.
// TESTING
// - Reset, then io_in=6'b100001 held 4 cycles: c_out=3'b000, c_all=0, tog_cnt all 0, fault=0.
// - io_in=6'b000011 at edge N: c_out=3'b001 after edge N. Then io_in=6'b000001: c_out[0] stays 1.
//   tog_cnt[0]=1.
// - io_in=6'b111111: c_out=3'b111 after 1 cycle, c_all=1 after 2 cycles.
//   Then io_in=6'b101001: all hold, c_all=1.
// - io_in=6'b000000 after the all-ones state: c_out=0 and c_all=0 at the next two edges.
//   Each tog_cnt[i]=2.
// - Toggle element 0 (io_in 6'b000011 <-> 6'b000000) 300 times with CNT_W=8: tog_cnt[0]=255 saturated.
// - Assert rst_n=0 asynchronously mid-cycle while c_out=3'b111:
//   outputs go to RESET_VAL immediately, before the next clk edge. Counters=0, fault=0.

Source files
------------

// File: rtl/muller_c_proj_formal_wrap.sv
// Clocked Muller C-element array: three 2-input elements on io_in plus a 3-input agreement element.
// Define FORMAL_PROPS_EN to compile the assertion/cover properties; ports and behaviour are unchanged.
module muller_c_proj_formal_wrap #(
  parameter logic RESET_VAL = 1'b0,
  parameter int   CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         io_in,
  output logic [2:0]         c_out,
  output logic               c_all,
  output logic [3*CNT_W-1:0] tog_cnt,
  output logic               fault
);

  logic [2:0]       c_q, c_d;
  logic             call_q, call_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             fault_q, fault_d;

  function automatic logic c_elem2(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a | b));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    c_d     = c_q;
    fault_d = fault_q;
    for (int i = 0; i < 3; i++) begin
      c_d[i]   = c_elem2(io_in[2*i], io_in[2*i+1], c_q[i]);
      cnt_d[i] = (c_d[i] != c_q[i]) ? sat_inc(cnt_q[i]) : cnt_q[i];
      // A state change while the inputs disagree means the hold rule was violated.
      if ((c_d[i] != c_q[i]) && (io_in[2*i] != io_in[2*i+1]))
        fault_d = 1'b1;
    end
    call_d = (&c_q) | (call_q & (|c_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= {3{RESET_VAL}};
      call_q  <= RESET_VAL;
      fault_q <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      c_q     <= c_d;
      call_q  <= call_d;
      fault_q <= fault_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign c_out = c_q;
  assign c_all = call_q;
  assign fault = fault_q;

  for (genvar g = 0; g < 3; g++) begin : g_cnt
    assign tog_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

`ifdef FORMAL_PROPS_EN
  for (genvar g = 0; g < 3; g++) begin : g_props
    a_hold_on_disagree : assert property (@(posedge clk) disable iff (!rst_n)
      (io_in[2*g] != io_in[2*g+1]) |=> $stable(c_out[g]));
    a_cnt_monotonic : assert property (@(posedge clk) disable iff (!rst_n)
      1'b1 |=> (tog_cnt[g*CNT_W +: CNT_W] >= $past(tog_cnt[g*CNT_W +: CNT_W])));
    c_rise : cover property (@(posedge clk) disable iff (!rst_n) $rose(c_out[g]));
    c_fall : cover property (@(posedge clk) disable iff (!rst_n) $fell(c_out[g]));
  end
  a_no_fault : assert property (@(posedge clk) disable iff (!rst_n) !fault);
  c_all_high : cover property (@(posedge clk) disable iff (!rst_n) c_all);
`endif

endmodule

// File: tb/tb_muller_c_proj_formal_wrap.sv
// Randomized bench for muller_c_proj_formal_wrap with an in-bench behavioural model
// and a few literal checkpoints from the directed scenarios.
module tb_muller_c_proj_formal_wrap;
  localparam int   CNT_W = 8;
  localparam logic RV    = 1'b0;
  localparam int   SAT   = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [5:0]         io_in = '0;
  logic [2:0]         c_out;
  logic               c_all;
  logic [3*CNT_W-1:0] tog_cnt;
  logic               fault;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [2:0] m_c;
  logic       m_all;
  int         m_cnt [3];

  muller_c_proj_formal_wrap #(.RESET_VAL(RV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .io_in(io_in),
    .c_out(c_out), .c_all(c_all), .tog_cnt(tog_cnt), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic int cnt_of(input logic [3*CNT_W-1:0] v, input int i);
    return int'(v[i*CNT_W +: CNT_W]);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: element output follows agreeing inputs, otherwise holds;
  // the agreement flag follows the three element states when they all agree.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_c   <= {3{RV}};
      m_all <= RV;
      for (int i = 0; i < 3; i++) m_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (io_in[2*i] == io_in[2*i+1]) begin
          m_c[i] <= io_in[2*i];
          if (io_in[2*i] != m_c[i] && m_cnt[i] < SAT) m_cnt[i] <= m_cnt[i] + 1;
        end
      end
      if (m_c == 3'b111) m_all <= 1'b1;
      else if (m_c == 3'b000) m_all <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("c_out", int'(c_out), int'(m_c));
      check("c_all", int'(c_all), int'(m_all));
      for (int i = 0; i < 3; i++) check($sformatf("tog_cnt[%0d]", i), cnt_of(tog_cnt, i), m_cnt[i]);
      check("fault", int'(fault), 0);
    end
  end

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    chk_en = 1'b1;
    rst_n  = 1'b0;
    io_in  = '0;
    cyc(3);
    check("reset c_out", int'(c_out), 0);
    check("reset fault", int'(fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    io_in = 6'b100001;
    cyc(4);
    check("hold c_out", int'(c_out), 0);
    check("hold c_all", int'(c_all), 0);
    check("hold cnt0", cnt_of(tog_cnt, 0), 0);
    check("hold fault", int'(fault), 0);

    io_in = 6'b000011;
    cyc(1);
    check("set e0", int'(c_out), 3'b001);
    io_in = 6'b000001;
    cyc(1);
    check("keep e0", int'(c_out), 3'b001);
    check("cnt0 one", cnt_of(tog_cnt, 0), 1);

    io_in = 6'b111111;
    cyc(1);
    check("all c_out", int'(c_out), 3'b111);
    cyc(1);
    check("all c_all", int'(c_all), 1);
    io_in = 6'b101001;
    cyc(1);
    check("all hold", int'(c_out), 3'b111);
    check("all hold c_all", int'(c_all), 1);

    io_in = 6'b000000;
    cyc(1);
    check("clr c_out", int'(c_out), 0);
    cyc(1);
    check("clr c_all", int'(c_all), 0);
    for (int i = 0; i < 3; i++) check("cnt two", cnt_of(tog_cnt, i), 2);

    for (int k = 0; k < 300; k++) begin
      io_in = (k % 2 == 0) ? 6'b000011 : 6'b000000;
      cyc(1);
    end
    check("cnt0 sat", cnt_of(tog_cnt, 0), SAT);
    check("cnt1 unchanged", cnt_of(tog_cnt, 1), 2);

    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 3))
        0:       io_in = 6'b111111;
        1:       io_in = 6'b000000;
        default: io_in = 6'($urandom);
      endcase
      cyc(1);
    end

    // Async reset mid-cycle while all elements are high.
    io_in = 6'b111111;
    cyc(2);
    check("pre-rst c_out", int'(c_out), 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async c_out", int'(c_out), 0);
    check("async c_all", int'(c_all), 0);
    check("async cnt0", cnt_of(tog_cnt, 0), 0);
    check("async fault", int'(fault), 0);
    @(negedge clk);
    io_in = 6'b010110;
    rst_n = 1'b1;
    cyc(5);
    check("rel disagree", int'(c_out), 0);

    for (int k = 0; k < 1500; k++) begin
      io_in = ($urandom_range(0, 1) == 0) ? 6'($urandom) : {3{2'($urandom_range(0, 1) * 3)}};
      cyc(1);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
